axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
// AXI4 subordinate (responder) backed by word-addressed SRAM; the memory end of the core's iBus/dBus masters.
// Independent read (AR/R) and write (AW/W/B) engines with INCR/FIXED bursts, one transaction in flight per direction.
// Used as on-chip boot/data RAM and as the bus-functional memory in core validation benches.
// PARAMETERS
// ADDR_W      32      byte-address width
// ID_W        8       AXI ID width (iBus instances tie upper bits)
// DEPTH_WORDS 4096    SRAM depth in 32-bit words, power of two
// BASE_ADDR   32'h0   byte address of word 0
// PORTS
// clk         in   1       clock, all logic on rising edge
// rst         in   1       asynchronous, active-low reset
// s_arvalid   in   1       read address valid
// s_arready   out  1       read address ready
// s_araddr    in   ADDR_W  read start byte address
// s_arid      in   ID_W    read ID
// s_arlen     in   8       beats-1
// s_arsize    in   3       must be 3'b010
// s_arburst   in   2       00 FIXED, 01 INCR
// s_rvalid    out  1       read data valid
// s_rready    in   1       read data ready
// s_rdata     out  32      read data
// s_rid       out  ID_W    echo of arid
// s_rresp     out  2       00 OKAY, 10 SLVERR, 11 DECERR
// s_rlast     out  1       final beat
// s_awvalid/s_awready/s_awaddr/s_awid/s_awlen/s_awsize/s_awburst  write address channel, same widths as AR
// s_wvalid    in   1       write data valid
// s_wready    out  1       write data ready
// s_wdata     in   32      write data
// s_wstrb     in   4       byte enables
// s_wlast     in   1       final write beat
// s_bvalid    out  1       write response valid
// s_bready    in   1       write response ready
// s_bid       out  ID_W    echo of awid
// s_bresp     out  2       write response code
// BEHAVIOUR
// - Reset (rst low): all valid/ready outputs 0, rdata/rid/bid/resp 0, FSMs to IDLE, beat counters 0; SRAM contents NOT cleared.
//   arready/awready rise on first clk edge after rst high. Reset mid-burst aborts silently; no partial R/B emitted.
// - Read FSM R_IDLE -> R_BEAT. R_IDLE: arready=1; on arvalid&arready latch addr/id/len/size/burst, go R_BEAT.
//   R_BEAT: arready=0; rvalid=1 from cycle after AR handshake (1-cycle latency); data registered, held stable while rready=0.
//   Each rvalid&rready advances beat; rlast=1 when beat==len; after last handshake return R_IDLE (next AR accepted 1 cycle later).
// - Write FSM W_IDLE -> W_DATA -> W_RESP. W_IDLE: awready=1, latch AW. W_DATA: wready=1; each wvalid&wready writes bytes with wstrb set.
//   Burst ends on wlast handshake -> W_RESP: bvalid=1 until bready, then W_IDLE. wvalid before AW accepted is not consumed.
// - Address per beat: word index = (addr - BASE_ADDR)>>2, addr[1:0] ignored; INCR adds 4 per beat, FIXED repeats; 32-bit wrap-around.
// - Errors: arsize/awsize != 010 or burst==10/11 -> SLVERR on every beat (rdata 0, writes suppressed).
//   Word index >= DEPTH_WORDS (or addr < BASE_ADDR) -> per-beat DECERR for reads (rdata 0), write beat dropped.
//   Write bresp = worst code over the burst (DECERR > SLVERR > OKAY); wlast early or late vs awlen -> SLVERR, burst still ends on wlast.
// - Simultaneous read and write of same word in same cycle: read returns old data (read-before-write).
// - Read and write channels fully independent; no ordering between them.
// TESTING
// - Reset: hold rst low, drive arvalid/awvalid -> all outputs 0; release -> arready=awready=1 next edge; SRAM preload intact.
// - Write 0xDEADBEEF strb 4'b0101 to 0x10 (old 0x11223344), then read 0x10 len 0 -> rdata 0x11AD33EF, rresp 00, rlast 1, rid echoed.
// - INCR read len 3 at 0x0 with rready toggling 1/0 -> 4 beats words 0..3, data stable during stalls, rlast only on beat 3.
// - Read 4*DEPTH_WORDS, len 1 -> two beats rresp 11 rdata 0; write same addr -> bresp 11, memory unchanged.
// - awlen 1 but wlast on first beat -> bresp 10, one word written; arsize 3'b001 read -> rresp 10.
// - Same-cycle read and write of word 5 (old 0xA, new 0xB) -> rdata 0xA; later read -> 0xB; rst low mid-burst -> rvalid 0 immediately.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate backed by a word-addressed 32-bit SRAM.
// Independent read (AR/R) and write (AW/W/B) engines, one burst in flight each.
// INCR/FIXED bursts; bad size/burst -> SLVERR, out-of-window beats -> DECERR.
module axi_sram_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                ID_W        = 8,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  // read address
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  // read data
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [ID_W-1:0]   s_rid,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  // write address
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  // write data
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  // write response
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic       {R_IDLE, R_BEAT}          r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Returns {hit, word_index}; the 33-bit subtract catches addresses below the base.
  function automatic logic [IDX_W:0] map_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] diff;
    logic [1:0]      unused_lsb;
    logic            hit;
    diff       = {1'b0, a} - {1'b0, BASE_ADDR};
    unused_lsb = diff[1:0];
    hit        = !diff[ADDR_W] && ((diff[ADDR_W-1:0] >> (IDX_W + 2)) == '0);
    return {hit, diff[IDX_W+1:2]};
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ------------------------------------------------------------------ read
  r_state_e          r_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [31:0]       rdata_q;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_len_q, r_beat_q;
  logic              r_slv_q, r_incr_q;

  logic [ADDR_W-1:0] r_next_addr, r_fetch_addr;
  logic              r_fetch_slv, r_hit, ar_bad;
  logic [IDX_W:0]    r_map;
  logic [1:0]        r_code;
  logic [31:0]       r_data;

  // Fetch address/data for the beat about to be presented (first beat comes straight off AR).
  always_comb begin
    ar_bad       = (s_arsize != 3'b010) || s_arburst[1];
    r_next_addr  = r_incr_q ? r_addr_q + ADDR_W'(4) : r_addr_q;
    r_fetch_addr = (r_state_q == R_IDLE) ? s_araddr : r_next_addr;
    r_fetch_slv  = (r_state_q == R_IDLE) ? ar_bad : r_slv_q;
    r_map        = map_addr(r_fetch_addr);
    r_hit        = r_map[IDX_W];
    r_code       = r_fetch_slv ? RESP_SLVERR : (!r_hit ? RESP_DECERR : RESP_OKAY);
    r_data       = (r_code == RESP_OKAY) ? mem_q[r_map[IDX_W-1:0]] : 32'h0;
  end

  // Read FSM: accept AR, then stream registered beats held stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_slv_q   <= 1'b0;
      r_incr_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (s_arvalid && arready_q) begin
            arready_q <= 1'b0;
            r_addr_q  <= s_araddr;
            r_len_q   <= s_arlen;
            r_beat_q  <= '0;
            r_slv_q   <= ar_bad;
            r_incr_q  <= (s_arburst == 2'b01);
            rid_q     <= s_arid;
            rdata_q   <= r_data;
            rresp_q   <= r_code;
            rlast_q   <= (s_arlen == 8'd0);
            rvalid_q  <= 1'b1;
            r_state_q <= R_BEAT;
          end
        end
        R_BEAT: begin
          if (s_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_beat_q <= r_beat_q + 8'd1;
              r_addr_q <= r_next_addr;
              rdata_q  <= r_data;
              rresp_q  <= r_code;
              rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rid     = rid_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;

  // ----------------------------------------------------------------- write
  w_state_e          w_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q, w_id_q;
  logic [1:0]        bresp_q, w_worst_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [7:0]        w_len_q, w_beat_q;
  logic              w_slv_q, w_incr_q;

  logic              aw_bad, w_len_bad, w_we;
  logic [IDX_W:0]    w_map;
  logic [1:0]        w_code, w_acc;

  // Per-beat response code, burst-length mismatch detection and running worst code.
  always_comb begin
    aw_bad    = (s_awsize != 3'b010) || s_awburst[1];
    w_map     = map_addr(w_addr_q);
    w_code    = w_slv_q ? RESP_SLVERR : (!w_map[IDX_W] ? RESP_DECERR : RESP_OKAY);
    w_len_bad = s_wlast ? (w_beat_q != w_len_q) : (w_beat_q == w_len_q);
    w_acc     = worst(worst(w_worst_q, w_code), w_len_bad ? RESP_SLVERR : RESP_OKAY);
    w_we      = (w_state_q == W_DATA) && s_wvalid && (w_code == RESP_OKAY);
  end

  // Write FSM: accept AW, absorb W beats until wlast, then hold B until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      w_id_q    <= '0;
      w_worst_q <= RESP_OKAY;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_slv_q   <= 1'b0;
      w_incr_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_addr_q  <= s_awaddr;
            w_id_q    <= s_awid;
            w_len_q   <= s_awlen;
            w_beat_q  <= '0;
            w_slv_q   <= aw_bad;
            w_incr_q  <= (s_awburst == 2'b01);
            w_worst_q <= RESP_OKAY;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_wvalid) begin
            w_beat_q  <= w_beat_q + 8'd1;
            w_addr_q  <= w_incr_q ? w_addr_q + ADDR_W'(4) : w_addr_q;
            w_worst_q <= w_acc;
            if (s_wlast) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_acc;
              bid_q     <= w_id_q;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // SRAM byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) mem_q[w_map[IDX_W-1:0]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bid     = bid_q;
  assign s_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: reset, strobed writes, INCR/FIXED
// reads with backpressure, DECERR/SLVERR paths, read-before-write, mid-burst reset.
module tb_axi_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arid, s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [7:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awid, s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_bid;
  logic [1:0]  s_bresp;

  axi_sram_responder dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [31:0] wdat [8];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [7:0]  rd_id   [16];
  int          rd_n;
  logic [1:0]  wr_bresp;
  logic [7:0]  wr_bid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Present AR and hold until accepted; returns at posedge+1 after handshake.
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic hs = 1'b0;
    s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_arready) begin hs = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic hs = 1'b0;
    s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_awready) begin hs = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  // Full read burst; optional rready toggling; checks data holds while stalled.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle);
    logic        done = 1'b0;
    logic        held_v = 1'b0;
    logic [31:0] held = '0;
    ar_send(addr, id, len, size, burst);
    rd_n = 0;
    s_rready = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (t == 0) chk("r_latency", {31'd0, s_rvalid}, 32'd1);
      if (held_v) begin chk("r_stall_hold", s_rdata, held); held_v = 1'b0; end
      if (s_rvalid && s_rready) begin
        if (rd_n < 16) begin
          rd_data[rd_n] = s_rdata; rd_resp[rd_n] = s_rresp;
          rd_last[rd_n] = s_rlast; rd_id[rd_n] = s_rid;
        end
        rd_n++;
        if (s_rlast) done = 1'b1;
      end else if (s_rvalid) begin
        held = s_rdata; held_v = 1'b1;
      end
      @(posedge clk); #1;
      if (toggle) s_rready = ~s_rready;
    end
    s_rready = 1'b0;
    if (!done) chk("r_timeout", 32'd0, 32'd1);
  endtask

  // Full write burst of nbeats from wdat[], wlast on the final driven beat.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [3:0] strb);
    logic hs;
    aw_send(addr, id, len, size, burst);
    for (int i = 0; i < nbeats; i++) begin
      s_wdata = wdat[i]; s_wstrb = strb; s_wlast = (i == nbeats - 1); s_wvalid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (s_wready) begin hs = 1'b1; break; end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (!hs) chk("w_timeout", 32'd0, 32'd1);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    s_bready = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_bvalid) begin hs = 1'b1; wr_bresp = s_bresp; wr_bid = s_bid; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_bready = 1'b0;
    if (!hs) begin chk("b_timeout", 32'd0, 32'd1); wr_bresp = 2'bxx; end
  endtask

  initial begin
    rst = 1'b0;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arsize = 3'b010; s_arburst = 2'b01;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awsize = 3'b010; s_awburst = 2'b01;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
    s_rready = 0; s_bready = 0;

    // Reset with request valids asserted: everything stays quiet.
    s_arvalid = 1; s_awvalid = 1; s_wvalid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {31'd0, s_arready}, 32'd0);
    chk("rst_awready", {31'd0, s_awready}, 32'd0);
    chk("rst_wready",  {31'd0, s_wready},  32'd0);
    chk("rst_rvalid",  {31'd0, s_rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, s_bvalid},  32'd0);
    chk("rst_rdata",   s_rdata, 32'd0);
    chk("rst_ids",     {16'd0, s_rid, s_bid}, 32'd0);
    chk("rst_resps",   {28'd0, s_rresp, s_bresp}, 32'd0);
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_arready", {31'd0, s_arready}, 32'd1);
    chk("rel_awready", {31'd0, s_awready}, 32'd1);

    // Preload: word4 = 0x11223344, words0..3 via INCR burst, word5 = 0xA.
    wdat[0] = 32'h11223344;
    do_write(32'h10, 8'h01, 8'd0, 3'b010, 2'b01, 1, 4'hF);
    chk("pre_bresp", {30'd0, wr_bresp}, 32'd0);
    wdat[0] = 32'h100; wdat[1] = 32'h101; wdat[2] = 32'h102; wdat[3] = 32'h103;
    do_write(32'h0, 8'h02, 8'd3, 3'b010, 2'b01, 4, 4'hF);
    chk("pre_incr_bresp", {30'd0, wr_bresp}, 32'd0);
    wdat[0] = 32'hA;
    do_write(32'h14, 8'h03, 8'd0, 3'b010, 2'b01, 1, 4'hF);

    // Reset pulse must not disturb SRAM contents.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Strobed write then single-beat read.
    wdat[0] = 32'hDEADBEEF;
    do_write(32'h10, 8'h5A, 8'd0, 3'b010, 2'b01, 1, 4'b0101);
    chk("strb_bresp", {30'd0, wr_bresp}, 32'd0);
    chk("strb_bid", {24'd0, wr_bid}, 32'h5A);
    do_read(32'h10, 8'h3C, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("strb_nbeats", rd_n, 1);
    chk("strb_rdata", rd_data[0], 32'h11AD33EF);
    chk("strb_rresp", {30'd0, rd_resp[0]}, 32'd0);
    chk("strb_rlast", {31'd0, rd_last[0]}, 32'd1);
    chk("strb_rid", {24'd0, rd_id[0]}, 32'h3C);

    // INCR len 3 with rready toggling.
    do_read(32'h0, 8'h21, 8'd3, 3'b010, 2'b01, 1'b1);
    chk("incr_nbeats", rd_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_data%0d", i), rd_data[i], 32'h100 + i);
      chk($sformatf("incr_last%0d", i), {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("incr_resp%0d", i), {30'd0, rd_resp[i]}, 32'd0);
    end

    // FIXED len 2 at word 1 repeats the same word.
    do_read(32'h4, 8'h22, 8'd2, 3'b010, 2'b00, 1'b0);
    chk("fixed_nbeats", rd_n, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("fixed_data%0d", i), rd_data[i], 32'h101);

    // Out-of-window read/write at 4*DEPTH_WORDS.
    do_read(32'h4000, 8'h30, 8'd1, 3'b010, 2'b01, 1'b0);
    chk("dec_nbeats", rd_n, 2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dec_resp%0d", i), {30'd0, rd_resp[i]}, 32'd3);
      chk($sformatf("dec_data%0d", i), rd_data[i], 32'd0);
    end
    wdat[0] = 32'hFFFFFFFF;
    do_write(32'h4000, 8'h31, 8'd0, 3'b010, 2'b01, 1, 4'hF);
    chk("dec_bresp", {30'd0, wr_bresp}, 32'd3);
    do_read(32'h0, 8'h32, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("dec_no_alias", rd_data[0], 32'h100);

    // Early wlast: awlen 1, one beat.
    wdat[0] = 32'h55;
    do_write(32'h20, 8'h40, 8'd1, 3'b010, 2'b01, 1, 4'hF);
    chk("early_bresp", {30'd0, wr_bresp}, 32'd2);
    do_read(32'h20, 8'h41, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("early_written", rd_data[0], 32'h55);

    // Bad size read.
    do_read(32'h0, 8'h42, 8'd0, 3'b001, 2'b01, 1'b0);
    chk("size_rresp", {30'd0, rd_resp[0]}, 32'd2);
    chk("size_rdata", rd_data[0], 32'd0);

    // Same-cycle read and write of word 5: read sees old value.
    aw_send(32'h14, 8'h50, 8'd0, 3'b010, 2'b01);
    s_wdata = 32'hB; s_wstrb = 4'hF; s_wlast = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h14; s_arid = 8'h51; s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01;
    s_arvalid = 1'b1;
    @(negedge clk);
    chk("rbw_wready", {31'd0, s_wready}, 32'd1);
    chk("rbw_arready", {31'd0, s_arready}, 32'd1);
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
    s_rready = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    chk("rbw_rvalid", {31'd0, s_rvalid}, 32'd1);
    chk("rbw_old", s_rdata, 32'hA);
    chk("rbw_bvalid", {31'd0, s_bvalid}, 32'd1);
    @(posedge clk); #1;
    s_rready = 1'b0; s_bready = 1'b0;
    do_read(32'h14, 8'h52, 8'd0, 3'b010, 2'b01, 1'b0);
    chk("rbw_new", rd_data[0], 32'hB);

    // Reset mid-burst drops rvalid at once.
    ar_send(32'h0, 8'h60, 8'd3, 3'b010, 2'b01);
    s_rready = 1'b0;
    @(negedge clk);
    chk("mid_rvalid_pre", {31'd0, s_rvalid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rvalid_rst", {31'd0, s_rvalid}, 32'd0);
    chk("mid_arready_rst", {31'd0, s_arready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_arready_rel", {31'd0, s_arready}, 32'd1);
    chk("mid_rvalid_rel", {31'd0, s_rvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
